sensor_monitor: RTL and testbench

SENSOR_MONITOR -- requirements
Module: sensor_monitor

---
 rtl/sensor_monitor.sv | 147 ++++++++++++++
 tb/tb_sensor_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_monitor.sv
// Per-channel debounced sensor error detection with sticky faults; optional event counter via SENSOR_MONITOR_CNT_EN.
// Latency: error/fault rise DEB_CYCLES-1 edges after the first edge that samples a persistent raw error.
// Backpressure: none; every channel is evaluated every cycle, and clr is a level sampled on each edge.
module sensor_monitor #(
  parameter int NUM_CH     = 4,
  parameter int DEB_CYCLES = 3,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*NUM_CH-1:0] sensors,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   clr,
  output logic [NUM_CH-1:0]   error,
  output logic [NUM_CH-1:0]   fault,
  output logic                any_fault
`ifdef SENSOR_MONITOR_CNT_EN
  ,
  output logic [CNT_W-1:0]    fault_cnt
`endif
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] deb_last = DW'(DEB_CYCLES);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_PEND = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  generate
    if (NUM_CH < 1 || NUM_CH > 16 || DEB_CYCLES < 1 || DEB_CYCLES > 255 || CNT_W < 1) begin : g_bad_cfg
      $error("sensor_monitor: parameter out of range");
    end
  endgenerate

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [DW-1:0]     cnt_q   [NUM_CH];
  logic [DW-1:0]     cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] enter_err;
  logic [NUM_CH-1:0] fault_q;
  logic [NUM_CH-1:0] fault_d;

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = sensors[4*i] | (sensors[4*i+1] & (sensors[4*i+2] | sensors[4*i+3]));
    end
  end

  // Any cycle without a qualified raw error drops the channel straight back to OK,
  // so debounce progress is never carried across a gap.
  always_comb begin
    enter_err = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!enable || !raw[i]) begin
        state_d[i] = ST_OK;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_OK: begin
            if (DEB_CYCLES == 1) begin
              state_d[i] = ST_ERR;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = ST_PEND;
              cnt_d[i]   = DW'(1);
            end
          end
          ST_PEND: begin
            cnt_d[i] = cnt_q[i] + DW'(1);
            if (cnt_q[i] + DW'(1) == deb_last) begin
              state_d[i] = ST_ERR;
            end
          end
          ST_ERR: begin
            state_d[i] = ST_ERR;
          end
          default: begin
            state_d[i] = ST_OK;
            cnt_d[i]   = '0;
          end
        endcase
      end
      enter_err[i] = (state_d[i] == ST_ERR) && (state_q[i] != ST_ERR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_OK;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // A new ERR entry outranks a clear on the same edge.
  assign fault_d = (fault_q & ~clr) | enter_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= '0;
    end else begin
      fault_q <= fault_d;
    end
  end

  always_comb begin
    error = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      error[i] = (state_q[i] == ST_ERR);
    end
  end

  assign fault     = fault_q;
  assign any_fault = |fault_q;

`ifdef SENSOR_MONITOR_CNT_EN
  logic [CNT_W-1:0] fault_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= '0;
    end else if (&clr) begin
      fault_cnt_q <= '0;
    end else if (|enter_err && fault_cnt_q != {CNT_W{1'b1}}) begin
      fault_cnt_q <= fault_cnt_q + CNT_W'(1);
    end
  end

  assign fault_cnt = fault_cnt_q;
`else
  // No event counter in this build.
`endif

endmodule

// File: tb/tb_sensor_monitor.sv
// Bench for sensor_monitor: directed scenarios plus randomized traffic against a run-length model.
module tb_sensor_monitor;

  localparam int NUM_CH = 4;
  localparam int DEB    = 3;
  localparam int CNT_W  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*NUM_CH-1:0] sensors;
  logic                enable;
  logic [NUM_CH-1:0]   clr;
  logic [NUM_CH-1:0]   error;
  logic [NUM_CH-1:0]   fault;
  logic                any_fault;
`ifdef SENSOR_MONITOR_CNT_EN
  logic [CNT_W-1:0]    fault_cnt;
`endif

  sensor_monitor #(.NUM_CH(NUM_CH), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sensors   (sensors),
    .enable    (enable),
    .clr       (clr),
    .error     (error),
    .fault     (fault),
    .any_fault (any_fault)
`ifdef SENSOR_MONITOR_CNT_EN
    ,
    .fault_cnt (fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: per channel, count consecutive qualified raw cycles (saturating at DEB).
  // A channel is in error once that run reaches DEB; an entry is the edge it first gets there.
  int                run     [NUM_CH];
  int                nrun    [NUM_CH];
  logic [NUM_CH-1:0] ent;
  logic [NUM_CH-1:0] m_error;
  logic [NUM_CH-1:0] m_fault;
  int                m_cnt;

  function automatic logic rawf(input logic [3:0] s);
    return s[0] | (s[1] & (s[2] | s[3]));
  endfunction

  always_comb begin
    ent     = '0;
    m_error = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nrun[i] = 0;
      if (enable && rawf(sensors[4*i +: 4])) nrun[i] = (run[i] >= DEB) ? DEB : run[i] + 1;
      ent[i]     = (nrun[i] == DEB) && (run[i] < DEB);
      m_error[i] = (run[i] >= DEB);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) run[i] <= 0;
      m_fault <= '0;
      m_cnt   <= 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) run[i] <= nrun[i];
      m_fault <= (m_fault & ~clr) | ent;
      if (&clr) m_cnt <= 0;
      else if (|ent && m_cnt < (1 << CNT_W) - 1) m_cnt <= m_cnt + 1;
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("error", 32'(error), 32'(m_error));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("any_fault", 32'(any_fault), 32'(|m_fault));
`ifdef SENSOR_MONITOR_CNT_EN
    chk("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst     = 1'b1;
    sensors = '0;
    enable  = 1'b1;
    clr     = '0;
    #2;
    chk("reset_error", 32'(error), 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);
    chk("reset_any", 32'(any_fault), 32'h0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    #1;

    // ch0 error held: asserts on the third sampling edge, drops next edge, fault sticks
    sensors = 16'h0001;
    tick();
    chk("c0_edge0_err", 32'(error), 32'h0);
    tick();
    tick();
    chk("c0_edge2_err", 32'(error), 32'h1);
    chk("c0_edge2_fault", 32'(fault), 32'h1);
    chk("c0_edge2_any", 32'(any_fault), 32'h1);
    sensors = 16'h0000;
    tick();
    chk("c0_drop_err", 32'(error), 32'h0);
    chk("c0_drop_fault", 32'(fault), 32'h1);
    clr = 4'b0001;
    tick();
    chk("c0_clr_fault", 32'(fault), 32'h0);
    clr = '0;

    // ch1: two-edge glitch is ignored, a full three-edge retry asserts
    sensors = 16'h0060;
    tick();
    tick();
    sensors = 16'h0000;
    tick();
    chk("c1_glitch_err", 32'(error), 32'h0);
    chk("c1_glitch_fault", 32'(fault), 32'h0);
    sensors = 16'h0060;
    tick();
    tick();
    chk("c1_retry2_err", 32'(error), 32'h0);
    tick();
    chk("c1_retry3_err", 32'(error), 32'h2);
    chk("c1_retry3_fault", 32'(fault), 32'h2);
    sensors = 16'h0000;
    clr     = 4'b0010;
    tick();
    chk("c1_clr_fault", 32'(fault), 32'h0);
    clr = '0;

    // ch2: clear coincident with ERR entry loses; a later clear works
    sensors = 16'h0A00;
    tick();
    tick();
    clr = 4'b0100;
    tick();
    chk("c2_entry_clr_fault", 32'(fault), 32'h4);
    chk("c2_entry_err", 32'(error), 32'h4);
    clr     = '0;
    sensors = 16'h0000;
    tick();
    chk("c2_hold_fault", 32'(fault), 32'h4);
    clr = 4'b0100;
    tick();
    chk("c2_late_clr_fault", 32'(fault), 32'h0);
    clr = '0;

    // ch3: reset mid-debounce discards progress
    sensors = 16'h1000;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("c3_rst_err", 32'(error), 32'h0);
    chk("c3_rst_fault", 32'(fault), 32'h0);
    chk("c3_rst_any", 32'(any_fault), 32'h0);
    compare_all();
    rst = 1'b0;
    tick();
    tick();
    chk("c3_post2_err", 32'(error), 32'h0);
    tick();
    chk("c3_post3_err", 32'(error), 32'h8);
    sensors = 16'h0000;
    clr     = 4'hF;
    tick();
    chk("c3_clrall_fault", 32'(fault), 32'h0);
    clr = '0;

    // enable low idles the FSM but keeps the sticky fault
    sensors = 16'h0001;
    tick();
    tick();
    tick();
    chk("en_err_on", 32'(error), 32'h1);
    enable = 1'b0;
    tick();
    chk("en_off_err", 32'(error), 32'h0);
    chk("en_off_fault", 32'(fault), 32'h1);
    enable = 1'b1;
    tick();
    tick();
    chk("en_back2_err", 32'(error), 32'h0);
    tick();
    chk("en_back3_err", 32'(error), 32'h1);
    sensors = 16'h0000;
    clr     = 4'hF;
    tick();
    clr = '0;

`ifdef SENSOR_MONITOR_CNT_EN
    for (int n = 0; n < 5; n++) begin
      sensors = 16'h0001;
      tick();
      tick();
      tick();
      sensors = 16'h0000;
      tick();
    end
    chk("cnt_saturated", 32'(fault_cnt), 32'h3);
    clr = 4'hF;
    tick();
    chk("cnt_cleared", 32'(fault_cnt), 32'h0);
    chk("cnt_fault_cleared", 32'(fault), 32'h0);
    clr = '0;
`endif

    // randomized traffic: sticky sensor values so debounce often completes
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 99) < 25) sensors[4*ch +: 4] = 4'($urandom);
      end
      enable = ($urandom_range(0, 99) < 95);
      clr    = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 99) < 8) clr[ch] = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) clr = '1;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        compare_all();
        rst = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
